// File: rtl/envelope_pkg.sv
// Shared types and default sizing for the envelope bank and its per-channel engine.
package envelope_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHold
    } env_state_e;

    localparam int unsigned DEF_NUM_CH = 4;
    localparam int unsigned DEF_VOL_W  = 4;
    localparam int unsigned DEF_PER_W  = 3;

endpackage

// File: rtl/envelope_channel.sv
// One volume-envelope engine: a tick-driven step counter with saturating volume.
// ENVELOPE_BANK_DONE_EN adds a registered done_o flag that is high while in hold.
module envelope_channel
    import envelope_pkg::*;
#(
    parameter int unsigned VOL_W = DEF_VOL_W,
    parameter int unsigned PER_W = DEF_PER_W
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             env_tick_i,
    input  logic             trigger_i,
    input  logic             add_i,
    input  logic [PER_W-1:0] period_i,
    input  logic [VOL_W-1:0] start_i,
    output logic [VOL_W-1:0] volume_o
`ifdef ENVELOPE_BANK_DONE_EN
    ,
    output logic             done_o
`endif
);

    localparam logic [VOL_W-1:0] VolMax = '1;
    localparam logic [VOL_W-1:0] VolOne = VOL_W'(1);
    localparam logic [PER_W-1:0] CntOne = PER_W'(1);

    env_state_e       state_q, state_d;
    logic [VOL_W-1:0] vol_q, vol_d;
    logic [PER_W-1:0] cnt_q, cnt_d;
    logic [VOL_W-1:0] vol_step;
    logic             at_bound;

    always_comb begin
        state_d  = state_q;
        vol_d    = vol_q;
        cnt_d    = cnt_q;
        vol_step = vol_q;
        // Saturating step: never wraps past either end of the range.
        if (add_i && (vol_q != VolMax)) begin
            vol_step = vol_q + VolOne;
        end else if (!add_i && (vol_q != '0)) begin
            vol_step = vol_q - VolOne;
        end
        at_bound = add_i ? (vol_step == VolMax) : (vol_step == '0);

        if (trigger_i) begin
            vol_d   = start_i;
            cnt_d   = period_i;
            state_d = (period_i != '0) ? StRun : StHold;
        end else if ((state_q == StRun) && env_tick_i) begin
            if (cnt_q > CntOne) begin
                cnt_d = cnt_q - CntOne;
            end else if (period_i == '0) begin
                // A zero live period disables the envelope without a final step.
                cnt_d   = '0;
                state_d = StHold;
            end else begin
                vol_d = vol_step;
                cnt_d = period_i;
                if (at_bound) begin
                    state_d = StHold;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            vol_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            vol_q   <= vol_d;
            cnt_q   <= cnt_d;
        end
    end

    assign volume_o = vol_q;

`ifdef ENVELOPE_BANK_DONE_EN
    logic done_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state_d == StHold);
        end
    end

    assign done_o = done_q;
`endif

endmodule

// File: rtl/envelope_bank.sv
// Bank of NUM_CH independent envelope channels sharing one envelope tick.
// ENVELOPE_BANK_DONE_EN adds the per-channel done output.
module envelope_bank
    import envelope_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned VOL_W  = DEF_VOL_W,
    parameter int unsigned PER_W  = DEF_PER_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    env_tick,
    input  logic [NUM_CH-1:0]       trigger,
    input  logic [NUM_CH-1:0]       envelope_add,
    input  logic [NUM_CH*PER_W-1:0] period,
    input  logic [NUM_CH*VOL_W-1:0] starting_volume,
    output logic [NUM_CH*VOL_W-1:0] volume
`ifdef ENVELOPE_BANK_DONE_EN
    ,
    output logic [NUM_CH-1:0]       done
`endif
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        envelope_channel #(
            .VOL_W(VOL_W),
            .PER_W(PER_W)
        ) u_ch (
            .clk_i     (clk),
            .reset_i   (reset),
            .env_tick_i(env_tick),
            .trigger_i (trigger[i]),
            .add_i     (envelope_add[i]),
            .period_i  (period[i*PER_W +: PER_W]),
            .start_i   (starting_volume[i*VOL_W +: VOL_W]),
            .volume_o  (volume[i*VOL_W +: VOL_W])
`ifdef ENVELOPE_BANK_DONE_EN
            ,
            .done_o    (done[i])
`endif
        );
    end

endmodule

// File: tb/tb_envelope_bank.sv
// Self-checking bench for envelope_bank: directed scenarios plus random traffic vs a model.
module tb_envelope_bank;

    localparam int NUM_CH = 4;
    localparam int VOL_W  = 4;
    localparam int PER_W  = 3;
    localparam int VMAX   = (1 << VOL_W) - 1;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    env_tick = 1'b0;
    logic [NUM_CH-1:0]       trigger = '0;
    logic [NUM_CH-1:0]       envelope_add = '0;
    logic [NUM_CH*PER_W-1:0] period = '0;
    logic [NUM_CH*VOL_W-1:0] starting_volume = '0;
    logic [NUM_CH*VOL_W-1:0] volume;
`ifdef ENVELOPE_BANK_DONE_EN
    logic [NUM_CH-1:0]       done;
`endif

    envelope_bank #(
        .NUM_CH(NUM_CH),
        .VOL_W (VOL_W),
        .PER_W (PER_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .env_tick       (env_tick),
        .trigger        (trigger),
        .envelope_add   (envelope_add),
        .period         (period),
        .starting_volume(starting_volume),
        .volume         (volume)
`ifdef ENVELOPE_BANK_DONE_EN
        ,
        .done           (done)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: volume, ticks remaining until next step, envelope active, finished.
    int mv[NUM_CH];
    int mleft[NUM_CH];
    bit mact[NUM_CH];
    bit mfin[NUM_CH];

    function automatic int vol_of(input int i);
        return int'(volume[i*VOL_W +: VOL_W]);
    endfunction

    task automatic set_ch(input int i, input int sv, input bit add, input int per);
        starting_volume[i*VOL_W +: VOL_W] = VOL_W'(sv);
        envelope_add[i] = add;
        period[i*PER_W +: PER_W] = PER_W'(per);
    endtask

    function automatic void model_edge();
        for (int i = 0; i < NUM_CH; i++) begin
            int p;
            p = int'(period[i*PER_W +: PER_W]);
            if (reset) begin
                mv[i] = 0; mleft[i] = 0; mact[i] = 0; mfin[i] = 0;
            end else if (trigger[i]) begin
                mv[i] = int'(starting_volume[i*VOL_W +: VOL_W]);
                mleft[i] = p;
                mact[i] = (p != 0);
                mfin[i] = (p == 0);
            end else if (mact[i] && env_tick) begin
                mleft[i] = mleft[i] - 1;
                if (mleft[i] == 0) begin
                    if (p == 0) begin
                        mact[i] = 0; mfin[i] = 1;
                    end else begin
                        if (envelope_add[i]) mv[i] = (mv[i] < VMAX) ? mv[i] + 1 : mv[i];
                        else mv[i] = (mv[i] > 0) ? mv[i] - 1 : 0;
                        mleft[i] = p;
                        if ((envelope_add[i] && mv[i] == VMAX) || (!envelope_add[i] && mv[i] == 0)) begin
                            mact[i] = 0; mfin[i] = 1;
                        end
                    end
                end
            end
        end
    endfunction

    // One clock: model sees the same inputs the DUT samples; outputs read 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic tick_once();
        env_tick = 1'b1;
        cycle();
        env_tick = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        trigger = '1;
        env_tick = 1'b1;
        for (int i = 0; i < NUM_CH; i++) set_ch(i, 9 + i, 1'b0, 2);
        cycle();
        cycle();
        for (int i = 0; i < NUM_CH; i++) begin
            total++;
            if (vol_of(i) !== 0) begin
                bad++;
                $display("FAIL reset_vol ch%0d got=%0d exp=0", i, vol_of(i));
            end
        end
`ifdef ENVELOPE_BANK_DONE_EN
        total++;
        if (done !== '0) begin
            bad++;
            $display("FAIL reset_done got=%b exp=0", done);
        end
`endif
        trigger = '0;
        env_tick = 1'b0;
        reset = 1'b0;
        cycle();
    endtask

    task automatic test_decay();
        int exp;
        set_ch(0, 10, 1'b0, 2);
        trigger = 4'b0001;
        cycle();
        trigger = '0;
        total++;
        if (vol_of(0) !== 10) begin
            bad++;
            $display("FAIL decay_load got=%0d exp=10", vol_of(0));
        end
        for (int k = 1; k <= 25; k++) begin
            tick_once();
            exp = (k >= 20) ? 0 : 10 - k / 2;
            total++;
            if (vol_of(0) !== exp) begin
                bad++;
                $display("FAIL decay_tick%0d got=%0d exp=%0d", k, vol_of(0), exp);
            end
        end
`ifdef ENVELOPE_BANK_DONE_EN
        total++;
        if (done[0] !== 1'b1) begin
            bad++;
            $display("FAIL decay_done got=%b exp=1", done[0]);
        end
`endif
    endtask

    task automatic test_attack_sat();
        set_ch(1, 14, 1'b1, 1);
        trigger = 4'b0010;
        cycle();
        trigger = '0;
        tick_once();
        total++;
        if (vol_of(1) !== 15) begin
            bad++;
            $display("FAIL attack_step got=%0d exp=15", vol_of(1));
        end
        tick_once();
        total++;
        if (vol_of(1) !== 15) begin
            bad++;
            $display("FAIL attack_hold got=%0d exp=15", vol_of(1));
        end
        set_ch(1, 15, 1'b1, 1);
        trigger = 4'b0010;
        cycle();
        trigger = '0;
        tick_once();
        total++;
        if (vol_of(1) !== 15) begin
            bad++;
            $display("FAIL attack_nowrap got=%0d exp=15", vol_of(1));
        end
`ifdef ENVELOPE_BANK_DONE_EN
        total++;
        if (done[1] !== 1'b1) begin
            bad++;
            $display("FAIL attack_done got=%b exp=1", done[1]);
        end
`endif
    endtask

    task automatic test_period0();
        set_ch(2, 7, 1'b0, 0);
        trigger = 4'b0100;
        cycle();
        trigger = '0;
`ifdef ENVELOPE_BANK_DONE_EN
        total++;
        if (done[2] !== 1'b1) begin
            bad++;
            $display("FAIL per0_done got=%b exp=1", done[2]);
        end
`endif
        for (int k = 0; k < 10; k++) begin
            tick_once();
            total++;
            if (vol_of(2) !== 7) begin
                bad++;
                $display("FAIL per0_tick%0d got=%0d exp=7", k, vol_of(2));
            end
        end
    endtask

    task automatic test_simultaneous();
        int exp0[3] = '{7, 6, 5};
        int exp3[3] = '{3, 3, 4};
        set_ch(0, 8, 1'b0, 1);
        trigger = 4'b0001;
        cycle();
        set_ch(3, 3, 1'b1, 2);
        trigger = 4'b1000;
        env_tick = 1'b1;
        cycle();
        trigger = '0;
        env_tick = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick_once();
            total++;
            if (vol_of(0) !== exp0[k] || vol_of(3) !== exp3[k]) begin
                bad++;
                $display("FAIL simul_step%0d got=%0d/%0d exp=%0d/%0d", k, vol_of(0), vol_of(3),
                         exp0[k], exp3[k]);
            end
        end
    endtask

    task automatic test_retrigger_reset();
        set_ch(0, 8, 1'b0, 3);
        trigger = 4'b0001;
        cycle();
        trigger = '0;
        for (int k = 0; k < 9; k++) tick_once();
        total++;
        if (vol_of(0) !== 5) begin
            bad++;
            $display("FAIL rtrg_pre got=%0d exp=5", vol_of(0));
        end
        set_ch(0, 12, 1'b0, 3);
        trigger = 4'b0001;
        cycle();
        trigger = '0;
        total++;
        if (vol_of(0) !== 12) begin
            bad++;
            $display("FAIL rtrg_load got=%0d exp=12", vol_of(0));
        end
        tick_once();
        tick_once();
        total++;
        if (vol_of(0) !== 12) begin
            bad++;
            $display("FAIL rtrg_cnt got=%0d exp=12", vol_of(0));
        end
        tick_once();
        total++;
        if (vol_of(0) !== 11) begin
            bad++;
            $display("FAIL rtrg_step got=%0d exp=11", vol_of(0));
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) tick_once();
        total++;
        if (vol_of(0) !== 0) begin
            bad++;
            $display("FAIL rst_abort got=%0d exp=0", vol_of(0));
        end
    endtask

    task automatic test_random();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                trigger[i] = ($urandom_range(0, 11) == 0);
                if ($urandom_range(0, 7) == 0) envelope_add[i] = 1'($urandom);
                if ($urandom_range(0, 9) == 0) period[i*PER_W +: PER_W] = PER_W'($urandom);
                starting_volume[i*VOL_W +: VOL_W] = VOL_W'($urandom);
            end
            env_tick = ($urandom_range(0, 2) != 0);
            reset = ($urandom_range(0, 99) == 0);
            cycle();
            for (int i = 0; i < NUM_CH; i++) begin
                total++;
                if (vol_of(i) !== mv[i]) begin
                    bad++;
                    $display("FAIL rand_vol cyc%0d ch%0d got=%0d exp=%0d", n, i, vol_of(i), mv[i]);
                end
`ifdef ENVELOPE_BANK_DONE_EN
                total++;
                if (done[i] !== mfin[i]) begin
                    bad++;
                    $display("FAIL rand_done cyc%0d ch%0d got=%b exp=%b", n, i, done[i], mfin[i]);
                end
`endif
            end
        end
        trigger = '0;
        env_tick = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_decay();
        test_attack_sat();
        test_period0();
        test_simultaneous();
        test_retrigger_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/envelope_bank.md
ENVELOPE_BANK -- requirements
Module: envelope_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent envelope channels (1..8).
REQ-002 SHALL have parameter VOL_W, default 4, volume width in bits.
REQ-003 SHALL have parameter PER_W, default 3, envelope period width in bits.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port env_tick  input  1  one-cycle envelope strobe from the frame sequencer.
REQ-007 SHALL have port trigger  input  NUM_CH  per-channel one-cycle restart strobe.
REQ-008 SHALL have port envelope_add  input  NUM_CH  per-channel direction; 1 = increment, 0 = decrement.
REQ-009 SHALL have port period  input  NUM_CH*PER_W  per-channel step period in ticks; channel i at bits [i*PER_W +: PER_W].
REQ-010 SHALL have port starting_volume  input  NUM_CH*VOL_W  per-channel start volume, packed as period.
REQ-011 SHALL have port volume  output  NUM_CH*VOL_W  per-channel current volume, registered, packed as period.

Function
REQ-012 Each channel SHALL run an independent FSM with states IDLE, RUN, HOLD.
REQ-013 On trigger[i], channel i SHALL load volume = starting_volume and counter = period, visible in the next cycle. If period is nonzero, the next state SHALL be RUN; otherwise it SHALL be HOLD.
REQ-014 trigger[i] SHALL take priority over env_tick in the same cycle; that tick is ignored for channel i.
REQ-015 In RUN on env_tick with counter > 1, the channel SHALL decrement the counter only.
REQ-016 In RUN on env_tick with counter == 1, the channel SHALL step the volume and reload the counter from the live period input.
REQ-017 The step of REQ-016 SHALL follow these rules:
- envelope_add=1 and volume < max: volume + 1.
- envelope_add=0 and volume > 0: volume - 1.
- Otherwise: volume unchanged.
REQ-018 The first volume step after a trigger SHALL occur on the period-th env_tick after the trigger.
REQ-019 If a step leaves volume at the boundary for its direction (max for add, 0 for subtract), the channel SHALL go to HOLD. A channel triggered already at the boundary SHALL hold at that boundary value, with no wrap, on its first step.
REQ-020 If the reloaded period is 0, the channel SHALL go to HOLD with volume unchanged.
REQ-021 envelope_add and the live period SHALL be sampled at every step/reload; changes between steps affect only later steps.
REQ-022 In IDLE and HOLD, volume SHALL remain constant until the next trigger.
REQ-023 Volume arithmetic SHALL be unsigned VOL_W-bit and SHALL never wrap; max = 2^VOL_W - 1.
REQ-024 env_tick in non-RUN states SHALL have no effect.

Reset
REQ-025 While reset is high at a rising edge, every channel SHALL go to IDLE with volume 0 and counter 0.
REQ-026 Reset SHALL override trigger and env_tick in the same cycle.
REQ-027 Reset asserted mid-envelope SHALL abort the envelope immediately, with no further steps until a new trigger.

Configuration
REQ-028 Macro ENVELOPE_BANK_DONE_EN SHALL gate an extra output port, done  output  NUM_CH.
- Defined: done[i] is high exactly while channel i is in HOLD, registered with state; reset value 0.
- Undefined: the port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Package envelope_pkg SHALL hold the state enum (IDLE/RUN/HOLD) and default-parameter constants.
REQ-030 Per-channel logic SHALL be sub-module envelope_channel, generated NUM_CH times; envelope_bank SHALL contain only packing/unpacking and the generate loop.

Verification
REQ-031 Reset: assert reset 2 cycles with triggers active -> all volume fields 0, done 0.
REQ-032 Decay: ch0 start=10, add=0, period=2; trigger, then 25 ticks -> volume 10,9,... stepping on ticks 2,4,6,...; reaches 0 at tick 20; done[0]=1; stays 0.
REQ-033 Attack saturation: ch1 start=14, add=1, period=1 -> 15 after tick 1, HOLD. Then ch1 start=15, add=1, period=1, retrigger -> stays 15 after tick 1, no wrap to 0.
REQ-034 Period 0: ch2 start=7, period=0; trigger, 10 ticks -> volume 7 constant, done[2]=1 immediately after trigger.
REQ-035 Simultaneous: trigger ch3 in the same cycle as env_tick while ch0 in RUN -> ch3 loads start and counter unaffected by the tick, ch0 steps normally, channels independent.
REQ-036 Retrigger/reset mid-run: ch0 at volume 5, RUN, period=3.
- Retrigger with start=12 -> next cycle 12, counter reloaded to 3.
- Assert reset instead -> volume 0, IDLE; later ticks have no effect.
